// File: rtl/speck_share_loader.sv
// speck_share_loader
// Accepts one plaintext/key block, splits both into two Boolean shares with
// fresh masks, streams the shares LSB-first into a masked Speck core, then
// holds Start for a fixed run window and pulses done when that window closes.
module speck_share_loader #(
    parameter int RUN_CYCLES = 3000,
    parameter int BLK        = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [BLK-1:0] pt,
    input  logic [BLK-1:0] key,
    input  logic [BLK-1:0] pt_mask,
    input  logic [BLK-1:0] key_mask,
    input  logic           carry_mask,
    output logic           data_ina,
    output logic           data_inb,
    output logic           k_data_ina,
    output logic           k_data_inb,
    output logic           carry_init_a,
    output logic           carry_init_b,
    output logic           we,
    output logic           Start,
    output logic           done
);

    // Counters never wrap, so a single bit is enough when a count of 1 is asked for.
    localparam int CNT_W = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [BLK-1:0]   sh_a;
    logic [BLK-1:0]   sh_b;
    logic [BLK-1:0]   sh_ka;
    logic [BLK-1:0]   sh_kb;
    logic [CNT_W-1:0] cnt_nxt;

    // Index of the bit presented in the following LOAD cycle.
    assign cnt_nxt = cnt + 1'b1;

    // Control FSM with registered outputs; every output reflects the state it is entered with.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            run_cnt      <= '0;
            sh_a         <= '0;
            sh_b         <= '0;
            sh_ka        <= '0;
            sh_kb        <= '0;
            req_ready    <= 1'b1;
            data_ina     <= 1'b0;
            data_inb     <= 1'b0;
            k_data_ina   <= 1'b0;
            k_data_inb   <= 1'b0;
            carry_init_a <= 1'b0;
            carry_init_b <= 1'b0;
            we           <= 1'b0;
            Start        <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // The unmasked words never reach a register; only shares are stored.
                        sh_a         <= pt ^ pt_mask;
                        sh_b         <= pt_mask;
                        sh_ka        <= key ^ key_mask;
                        sh_kb        <= key_mask;
                        cnt          <= '0;
                        state        <= LOAD;
                        req_ready    <= 1'b0;
                        we           <= 1'b1;
                        data_ina     <= pt[0] ^ pt_mask[0];
                        data_inb     <= pt_mask[0];
                        k_data_ina   <= key[0] ^ key_mask[0];
                        k_data_inb   <= key_mask[0];
                        carry_init_a <= carry_mask;
                        carry_init_b <= carry_mask;
                    end
                end
                LOAD: begin
                    if (cnt == CNT_LAST) begin
                        state      <= RUN;
                        run_cnt    <= '0;
                        we         <= 1'b0;
                        data_ina   <= 1'b0;
                        data_inb   <= 1'b0;
                        k_data_ina <= 1'b0;
                        k_data_inb <= 1'b0;
                        Start      <= 1'b1;
                    end else begin
                        cnt        <= cnt_nxt;
                        data_ina   <= sh_a[cnt_nxt];
                        data_inb   <= sh_b[cnt_nxt];
                        k_data_ina <= sh_ka[cnt_nxt];
                        k_data_inb <= sh_kb[cnt_nxt];
                    end
                end
                RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        state <= DONE;
                        Start <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    done         <= 1'b0;
                    req_ready    <= 1'b1;
                    carry_init_a <= 1'b0;
                    carry_init_b <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speck_share_loader.sv
// Directed bench for speck_share_loader: a full-size instance for the
// zero-mask, back-to-back and abort scenarios, and a BLK=8 / RUN_CYCLES=1
// instance for random-mask share checks over many blocks.
module tb_speck_share_loader;

    localparam logic [127:0] PT1  = 128'h6c617669757165207469206564616d20;
    localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT2  = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] PT3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY3 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Full-size instance
    logic         a_rst, a_req_valid, a_req_ready;
    logic [127:0] a_pt, a_key, a_pt_mask, a_key_mask;
    logic         a_carry_mask;
    logic         a_data_ina, a_data_inb, a_k_data_ina, a_k_data_inb;
    logic         a_carry_init_a, a_carry_init_b, a_we, a_Start, a_done;

    speck_share_loader #(.RUN_CYCLES(3000), .BLK(128)) dut_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .pt(a_pt), .key(a_key), .pt_mask(a_pt_mask), .key_mask(a_key_mask),
        .carry_mask(a_carry_mask),
        .data_ina(a_data_ina), .data_inb(a_data_inb),
        .k_data_ina(a_k_data_ina), .k_data_inb(a_k_data_inb),
        .carry_init_a(a_carry_init_a), .carry_init_b(a_carry_init_b),
        .we(a_we), .Start(a_Start), .done(a_done)
    );

    // Small instance
    logic       b_rst, b_req_valid, b_req_ready;
    logic [7:0] b_pt, b_key, b_pt_mask, b_key_mask;
    logic       b_carry_mask;
    logic       b_data_ina, b_data_inb, b_k_data_ina, b_k_data_inb;
    logic       b_carry_init_a, b_carry_init_b, b_we, b_Start, b_done;

    speck_share_loader #(.RUN_CYCLES(1), .BLK(8)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .pt(b_pt), .key(b_key), .pt_mask(b_pt_mask), .key_mask(b_key_mask),
        .carry_mask(b_carry_mask),
        .data_ina(b_data_ina), .data_inb(b_data_inb),
        .k_data_ina(b_k_data_ina), .k_data_inb(b_k_data_inb),
        .carry_init_a(b_carry_init_a), .carry_init_b(b_carry_init_b),
        .we(b_we), .Start(b_Start), .done(b_done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_outs_idle(input string tag);
        check(tag, {a_we, a_Start, a_done, a_data_ina, a_data_inb, a_k_data_ina,
                    a_k_data_inb, a_carry_init_a, a_carry_init_b}, 0);
        check({tag, "_rdy"}, a_req_ready, 1);
    endtask

    initial begin
        logic [127:0] ptv, keyv;
        int t, starts, we_run, done_cyc, low;

        a_rst = 1'b1; a_req_valid = 1'b0; a_pt = '0; a_key = '0;
        a_pt_mask = '0; a_key_mask = '0; a_carry_mask = 1'b0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_pt = '0; b_key = '0;
        b_pt_mask = '0; b_key_mask = '0; b_carry_mask = 1'b0;
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;
        a_outs_idle("reset");
        check("reset_b_rdy", b_req_ready, 1);

        // Zero masks: shares a carry the plaintext/key, shares b are zero
        ptv = PT1; keyv = KEY1;
        a_pt = PT1; a_key = KEY1; a_carry_mask = 1'b1; a_req_valid = 1'b1;
        tick();
        t = 1;
        a_req_valid = 1'b0; a_pt = PT2; a_key = PT3; a_carry_mask = 1'b0;
        for (int i = 0; i < 128; i++) begin
            check("zm_we", a_we, 1);
            check("zm_rdy", a_req_ready, 0);
            check("zm_a", a_data_ina, ptv[i]);
            check("zm_b", a_data_inb, 0);
            check("zm_ka", a_k_data_ina, keyv[i]);
            check("zm_kb", a_k_data_inb, 0);
            check("zm_cinit", {a_carry_init_a, a_carry_init_b}, 2'b11);
            tick(); t++;
        end
        starts = 0; we_run = 0; done_cyc = -1;
        for (int n = 0; n < 4000 && done_cyc < 0; n++) begin
            if (a_done) begin
                done_cyc = t;
                check("done_start", a_Start, 0);
            end else begin
                if (a_Start) starts++;
                if (a_we) we_run++;
            end
            tick(); t++;
        end
        check("run_len", starts, 3000);
        check("run_we", we_run, 0);
        check("done_cyc", done_cyc, 1 + 128 + 3000);
        a_outs_idle("after_done");

        // req_valid held high: busy from LOAD through DONE, next accept after one IDLE cycle
        a_pt_mask = {4{$urandom}}; a_key_mask = {4{$urandom}}; a_req_valid = 1'b1;
        tick();
        low = 0;
        while (!a_req_ready && low < 5000) begin
            low++;
            tick();
        end
        check("busy_len", low, 128 + 3000 + 1);
        ptv = PT2;
        a_pt = PT2; a_pt_mask = '0; a_key_mask = '0;
        tick();
        check("reaccept_we", a_we, 1);
        check("reaccept_rdy", a_req_ready, 0);
        a_req_valid = 1'b0;

        // Abort during LOAD at cnt=57
        for (int i = 0; i < 57; i++) tick();
        check("ld57_bit", a_data_ina, ptv[57]);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        a_outs_idle("rst_load");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_load_nodone", a_done, 0);
        end

        // Fresh request after abort starts from bit 0
        ptv = PT3; keyv = KEY3;
        a_pt = PT3; a_key = KEY3; a_carry_mask = 1'b0; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        for (int i = 0; i < 128; i++) begin
            check("rl_a", a_data_ina, ptv[i]);
            check("rl_ka", a_k_data_ina, keyv[i]);
            tick();
        end
        check("rl_start", a_Start, 1);

        // Abort during RUN at cycle 1500
        for (int i = 0; i < 1500; i++) tick();
        check("run1500_start", a_Start, 1);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        a_outs_idle("rst_run");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_run_nodone", a_done, 0);
        end

        // Reset wins over a simultaneous handshake
        a_rst = 1'b1; a_req_valid = 1'b1; a_pt = PT1;
        tick();
        a_rst = 1'b0; a_req_valid = 1'b0;
        a_outs_idle("rst_hs");
        tick();
        a_outs_idle("rst_hs2");

        // Small instance, random masks: share XOR and b-share values
        for (int blk = 0; blk < 1000; blk++) begin
            logic [7:0] p, k, pm, km;
            logic       cmv;
            p = 8'($urandom); k = 8'($urandom); pm = 8'($urandom); km = 8'($urandom);
            cmv = 1'($urandom);
            b_pt = p; b_key = k; b_pt_mask = pm; b_key_mask = km; b_carry_mask = cmv;
            b_req_valid = 1'b1;
            tick();
            b_req_valid = 1'b0;
            b_pt = 8'($urandom); b_key = 8'($urandom);
            b_pt_mask = 8'($urandom); b_key_mask = 8'($urandom); b_carry_mask = ~cmv;
            for (int i = 0; i < 8; i++) begin
                check("rm_we", b_we, 1);
                check("rm_x", b_data_ina ^ b_data_inb, p[i]);
                check("rm_b", b_data_inb, pm[i]);
                check("rm_kx", b_k_data_ina ^ b_k_data_inb, k[i]);
                check("rm_kb", b_k_data_inb, km[i]);
                check("rm_cinit", {b_carry_init_a, b_carry_init_b}, {cmv, cmv});
                tick();
            end
            check("rm_run", {b_we, b_Start, b_done}, 3'b010);
            tick();
            check("rm_done", {b_we, b_Start, b_done}, 3'b001);
            tick();
            check("rm_idle", {b_req_ready, b_done, b_carry_init_a, b_carry_init_b}, 4'b1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
